// File: rtl/mac_seq.sv
// Operand sequencer for the mac unit: queues (last, B, C) terms, issues them one at a
// time over Load/Done, chains each result back as the accumulator, emits one result per vector.
module mac_seq #(
    parameter int DEPTH = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       In_valid,
    output logic       In_ready,
    input  logic [7:0] B_in,
    input  logic [7:0] C_in,
    input  logic       Last_in,
    output logic [7:0] Mac_Ain,
    output logic [7:0] Mac_B,
    output logic [7:0] Mac_C,
    output logic       Mac_Load,
    input  logic       Mac_Done,
    input  logic [7:0] Mac_Aout,
    output logic [7:0] Result,
    output logic       Result_valid,
    input  logic       Result_ready,
    output logic       Busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

    logic [16:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q;
    logic [7:0]    acc_q, result_q;
    logic          rv_q, load_q;

    logic          push, pop, empty, head_last;
    logic [16:0]   head;

    assign empty     = (count_q == '0);
    assign In_ready  = (count_q != CW'(DEPTH));
    assign push      = In_valid & In_ready;
    assign pop       = (state_q == WAIT) & Mac_Done & ~empty;
    assign head      = mem_q[rd_ptr_q];
    assign head_last = head[16];

    // An empty FIFO presents zero operands rather than stale storage.
    assign Mac_B        = empty ? 8'd0 : head[15:8];
    assign Mac_C        = empty ? 8'd0 : head[7:0];
    assign Mac_Ain      = acc_q;
    assign Mac_Load     = load_q;
    assign Result       = result_q;
    assign Result_valid = rv_q;
    assign Busy         = (state_q != IDLE);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {Last_in, B_in, C_in};
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            acc_q    <= 8'd0;
            result_q <= 8'd0;
            rv_q     <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;

            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_q <= ISSUE;
                        load_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    load_q  <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // Only the first Done cycle matters: leaving WAIT masks any that follow.
                    if (pop) begin
                        if (!head_last) begin
                            acc_q <= Mac_Aout;
                            if (count_d != '0) begin
                                state_q <= ISSUE;
                                load_q  <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            result_q <= Mac_Aout;
                            rv_q     <= 1'b1;
                            acc_q    <= 8'd0;
                            state_q  <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (Result_ready) begin
                        rv_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    load_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: a behavioural mac (Done 3 cycles after Load) plus a vector table
// and directed sequences for backpressure, output stall, stray Done and mid-run reset.
module tb_mac_seq;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       In_valid = 1'b0;
    logic       In_ready;
    logic [7:0] B_in = 8'd0;
    logic [7:0] C_in = 8'd0;
    logic       Last_in = 1'b0;
    logic [7:0] Mac_Ain, Mac_B, Mac_C;
    logic       Mac_Load;
    logic       Mac_Done;
    logic [7:0] Mac_Aout;
    logic [7:0] Result;
    logic       Result_valid;
    logic       Result_ready = 1'b0;
    logic       Busy;

    mac_seq #(.DEPTH(4)) dut (
        .Clk(Clk), .Reset(Reset), .In_valid(In_valid), .In_ready(In_ready),
        .B_in(B_in), .C_in(C_in), .Last_in(Last_in),
        .Mac_Ain(Mac_Ain), .Mac_B(Mac_B), .Mac_C(Mac_C), .Mac_Load(Mac_Load),
        .Mac_Done(Mac_Done), .Mac_Aout(Mac_Aout),
        .Result(Result), .Result_valid(Result_valid), .Result_ready(Result_ready),
        .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // Behavioural mac: computes (Ain + B*C) mod 256 at Load, raises Done 3 cycles later.
    logic       pend = 1'b0;
    int         lat = 0;
    logic       auto_done = 1'b0;
    logic       stray = 1'b0;
    logic       mac_en = 1'b1;
    logic [7:0] aout_v = 8'd0;
    logic [7:0] ain_log [16];
    int         ain_n = 0;

    assign Mac_Done = auto_done | stray;
    assign Mac_Aout = auto_done ? aout_v : 8'hA5;

    always @(negedge Clk) begin
        auto_done = 1'b0;
        if (!Reset) begin
            pend = 1'b0;
        end else if (pend) begin
            if (lat <= 1) begin
                auto_done = 1'b1;
                pend = 1'b0;
            end else begin
                lat = lat - 1;
            end
        end else if (Mac_Load && mac_en) begin
            pend = 1'b1;
            lat = 3;
            aout_v = Mac_Ain + Mac_B * Mac_C;
        end
        if (Reset && Mac_Load && ain_n < 16) begin
            ain_log[ain_n] = Mac_Ain;
            ain_n = ain_n + 1;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic [7:0] c, input logic l);
        int g;
        g = 0;
        In_valid = 1'b1; B_in = b; C_in = c; Last_in = l;
        while (!In_ready && g < 100) begin
            @(negedge Clk);
            g++;
        end
        chk("push_ready", {31'd0, In_ready}, 32'd1);
        @(negedge Clk);
        In_valid = 1'b0;
    endtask

    task automatic wait_rv(input string nm);
        int g;
        g = 0;
        while (!Result_valid && g < 200) begin
            @(negedge Clk);
            g++;
        end
        chk({nm, "_rv"}, {31'd0, Result_valid}, 32'd1);
    endtask

    task automatic ack();
        Result_ready = 1'b1;
        @(negedge Clk);
        Result_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_in_ready"}, {31'd0, In_ready}, 32'd1);
        chk({nm, "_load"}, {31'd0, Mac_Load}, 32'd0);
        chk({nm, "_ain"}, {24'd0, Mac_Ain}, 32'd0);
        chk({nm, "_b"}, {24'd0, Mac_B}, 32'd0);
        chk({nm, "_c"}, {24'd0, Mac_C}, 32'd0);
        chk({nm, "_result"}, {24'd0, Result}, 32'd0);
        chk({nm, "_rvalid"}, {31'd0, Result_valid}, 32'd0);
        chk({nm, "_busy"}, {31'd0, Busy}, 32'd0);
    endtask

    typedef struct packed {
        logic [2:0]      n;
        logic [3:0][7:0] b;
        logic [3:0][7:0] c;
        logic [3:0][7:0] ain;
        logic [7:0]      res;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int acc_cnt;
        int g;
        int n0;

        // index 0 of each packed array is the first term (rightmost in the concatenation)
        tbl[0].n = 3'd2; tbl[0].b = {8'd0, 8'd0, 8'd2, 8'd3};
        tbl[0].c = {8'd0, 8'd0, 8'd5, 8'd4};   tbl[0].ain = {8'd0, 8'd0, 8'd12, 8'd0};  tbl[0].res = 8'd22;
        tbl[1].n = 3'd2; tbl[1].b = {8'd0, 8'd0, 8'd5, 8'd16};
        tbl[1].c = {8'd0, 8'd0, 8'd1, 8'd16};  tbl[1].ain = {8'd0, 8'd0, 8'd0, 8'd0};   tbl[1].res = 8'd5;
        tbl[2].n = 3'd3; tbl[2].b = {8'd0, 8'd7, 8'd20, 8'd10};
        tbl[2].c = {8'd0, 8'd9, 8'd3, 8'd10};  tbl[2].ain = {8'd0, 8'd160, 8'd100, 8'd0}; tbl[2].res = 8'd223;
        tbl[3].n = 3'd2; tbl[3].b = {8'd0, 8'd0, 8'd100, 8'd200};
        tbl[3].c = {8'd0, 8'd0, 8'd1, 8'd2};   tbl[3].ain = {8'd0, 8'd0, 8'd144, 8'd0}; tbl[3].res = 8'd244;
        tbl[4].n = 3'd1; tbl[4].b = {8'd0, 8'd0, 8'd0, 8'd255};
        tbl[4].c = {8'd0, 8'd0, 8'd0, 8'd255}; tbl[4].ain = {8'd0, 8'd0, 8'd0, 8'd0};   tbl[4].res = 8'd1;

        // Reset state
        repeat (3) @(negedge Clk);
        chk_reset_vals("reset");
        Reset = 1'b1;
        @(negedge Clk);

        // Table of complete vectors
        for (int i = 0; i < 5; i++) begin
            ain_n = 0;
            for (int j = 0; j < int'(tbl[i].n); j++) begin
                push(tbl[i].b[j], tbl[i].c[j], (j == int'(tbl[i].n) - 1));
            end
            wait_rv($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_result", i), {24'd0, Result}, {24'd0, tbl[i].res});
            chk($sformatf("vec%0d_busy", i), {31'd0, Busy}, 32'd1);
            chk($sformatf("vec%0d_loads", i), ain_n, {29'd0, tbl[i].n});
            for (int j = 0; j < int'(tbl[i].n); j++) begin
                chk($sformatf("vec%0d_ain%0d", i, j), {24'd0, ain_log[j]}, {24'd0, tbl[i].ain[j]});
            end
            ack();
            chk($sformatf("vec%0d_rv_clear", i), {31'd0, Result_valid}, 32'd0);
        end

        // Output stall with a second vector queued
        ain_n = 0;
        push(8'd1, 8'd1, 1'b1);
        push(8'd2, 8'd3, 1'b1);
        wait_rv("stall");
        chk("stall_result", {24'd0, Result}, 32'd1);
        n0 = ain_n;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            chk("stall_hold_result", {24'd0, Result}, 32'd1);
            chk("stall_hold_rv", {31'd0, Result_valid}, 32'd1);
            chk("stall_no_load", {31'd0, Mac_Load}, 32'd0);
        end
        chk("stall_load_count", ain_n, n0);
        ack();
        ain_n = 0;
        wait_rv("stall2");
        chk("stall2_result", {24'd0, Result}, 32'd6);
        chk("stall2_loads", ain_n, 1);
        chk("stall2_ain", {24'd0, ain_log[0]}, 32'd0);
        ack();

        // Backpressure: no Done from mac, In_valid held for 6 entries
        mac_en = 1'b0;
        acc_cnt = 0;
        B_in = 8'd1; C_in = 8'd1; Last_in = 1'b1;
        In_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (In_valid && In_ready) acc_cnt++;
            @(negedge Clk);
            if (acc_cnt == 6) In_valid = 1'b0;
        end
        chk("bp_accepted", acc_cnt, 4);
        chk("bp_in_ready", {31'd0, In_ready}, 32'd0);
        stray = 1'b1;
        @(negedge Clk);
        stray = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (In_valid && In_ready) acc_cnt++;
            @(negedge Clk);
            if (acc_cnt == 6) In_valid = 1'b0;
        end
        chk("bp_accepted_after_done", acc_cnt, 5);
        chk("bp_in_ready_after", {31'd0, In_ready}, 32'd0);
        chk("bp_result", {24'd0, Result}, 32'h000000A5);
        chk("bp_rv", {31'd0, Result_valid}, 32'd1);
        In_valid = 1'b0;
        Reset = 1'b0;
        #1;
        chk_reset_vals("bp_reset");
        @(negedge Clk);
        Reset = 1'b1;
        mac_en = 1'b1;
        @(negedge Clk);

        // Stray Done in IDLE (empty), then in IDLE (non-empty) and ISSUE
        stray = 1'b1;
        @(negedge Clk);
        stray = 1'b0;
        chk("stray_idle_busy", {31'd0, Busy}, 32'd0);
        chk("stray_idle_rv", {31'd0, Result_valid}, 32'd0);
        chk("stray_idle_in_ready", {31'd0, In_ready}, 32'd1);
        chk("stray_idle_ain", {24'd0, Mac_Ain}, 32'd0);
        ain_n = 0;
        push(8'd3, 8'd4, 1'b0);
        stray = 1'b1;
        push(8'd1, 8'd1, 1'b1);
        @(negedge Clk);
        stray = 1'b0;
        chk("stray_head_b", {24'd0, Mac_B}, 32'd3);
        chk("stray_head_c", {24'd0, Mac_C}, 32'd4);
        chk("stray_acc", {24'd0, Mac_Ain}, 32'd0);
        wait_rv("stray");
        chk("stray_result", {24'd0, Result}, 32'd13);
        chk("stray_loads", ain_n, 2);
        chk("stray_ain1", {24'd0, ain_log[1]}, 32'd12);
        ack();

        // Reset mid-WAIT with 3 entries queued and acc=12
        ain_n = 0;
        push(8'd3, 8'd4, 1'b0);
        push(8'd1, 8'd1, 1'b0);
        push(8'd1, 8'd1, 1'b0);
        push(8'd1, 8'd1, 1'b1);
        g = 0;
        while (ain_n < 2 && g < 50) begin
            @(negedge Clk);
            #1;
            g++;
        end
        chk("rst_second_load", ain_n, 2);
        @(negedge Clk);
        chk("rst_pre_acc", {24'd0, Mac_Ain}, 32'd12);
        chk("rst_pre_busy", {31'd0, Busy}, 32'd1);
        Reset = 1'b0;
        #1;
        chk_reset_vals("rst_wait");
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("rst_after_in_ready", {31'd0, In_ready}, 32'd1);
        chk("rst_after_busy", {31'd0, Busy}, 32'd0);
        ain_n = 0;
        push(8'd2, 8'd2, 1'b1);
        wait_rv("rst_next");
        chk("rst_next_result", {24'd0, Result}, 32'd4);
        chk("rst_next_loads", ain_n, 1);
        chk("rst_next_ain", {24'd0, ain_log[0]}, 32'd0);
        ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
